// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: arbiter state encoding, default timeout/error data, request payload.
package mem_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned CNT_W  = 8;

    localparam int unsigned        DEFAULT_TIMEOUT  = 255;
    localparam logic [DATA_W-1:0]  DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              instr;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] wdata;
        logic [ADDR_W-1:0] addr;
    } mem_req_t;

endpackage

// File: rtl/mem_req_mux.sv
// Combinational 2:1 select of master request fields onto the memory-controller side.
module mem_req_mux
    import mem_bus_pkg::*;
(
    input  mem_req_t req0,
    input  mem_req_t req1,
    input  logic     sel,
    output mem_req_t req
);

    assign req = sel ? req1 : req0;

endmodule

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter with alternating priority, per-grant timeout and mandatory idle gap.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned       TIMEOUT  = DEFAULT_TIMEOUT,
    parameter logic [DATA_W-1:0] ERR_DATA = DEFAULT_ERR_DATA
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_valid,
    input  logic              m0_instr,
    input  logic [STRB_W-1:0] m0_wstrb,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_valid,
    input  logic              m1_instr,
    input  logic [STRB_W-1:0] m1_wstrb,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              s_valid,
    output logic              s_instr,
    output logic [STRB_W-1:0] s_wstrb,
    output logic [DATA_W-1:0] s_wdata,
    output logic [ADDR_W-1:0] s_addr,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rdata,

    output logic              timeout_err
);

    arb_state_t       state;
    logic             prio;
    logic [CNT_W-1:0] cnt;

    logic     granted;
    logic     sel;
    logic     g_valid;
    logic     timeout_hit;
    logic     done;
    mem_req_t req0;
    mem_req_t req1;
    mem_req_t req_sel;

    assign granted     = (state == ST_GRANT0) || (state == ST_GRANT1);
    assign sel         = (state == ST_GRANT1);
    assign g_valid     = sel ? m1_valid : m0_valid;
    assign timeout_hit = granted && g_valid && !s_ready && (cnt == CNT_W'(TIMEOUT - 1));
    assign done        = granted && g_valid && (s_ready || timeout_hit);

    assign req0 = '{instr: m0_instr, wstrb: m0_wstrb, wdata: m0_wdata, addr: m0_addr};
    assign req1 = '{instr: m1_instr, wstrb: m1_wstrb, wdata: m1_wdata, addr: m1_addr};

    mem_req_mux u_mux (
        .req0 (req0),
        .req1 (req1),
        .sel  (sel),
        .req  (req_sel)
    );

    // Grant sequencing; every grant returns to IDLE so the controller sees s_valid drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            prio  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (m0_valid && (!m1_valid || !prio)) begin
                        state <= ST_GRANT0;
                    end else if (m1_valid) begin
                        state <= ST_GRANT1;
                    end
                end
                ST_GRANT0, ST_GRANT1: begin
                    if (!g_valid) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (done) begin
                        state <= ST_IDLE;
                        prio  <= !sel;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Completion and read data are combinational from the controller for zero added latency.
    always_comb begin
        s_valid     = granted;
        s_instr     = req_sel.instr;
        s_wstrb     = req_sel.wstrb;
        s_wdata     = req_sel.wdata;
        s_addr      = req_sel.addr;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        m0_rdata    = '0;
        m1_rdata    = '0;
        timeout_err = timeout_hit;
        if (state == ST_GRANT0) begin
            m0_ready = done;
            m0_rdata = timeout_hit ? ERR_DATA : s_rdata;
        end else if (state == ST_GRANT1) begin
            m1_ready = done;
            m1_rdata = timeout_hit ? ERR_DATA : s_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT=4).
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_valid, m0_instr, m0_ready;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_wdata, m0_addr, m0_rdata;
    logic        m1_valid, m1_instr, m1_ready;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_wdata, m1_addr, m1_rdata;
    logic        s_valid, s_instr, s_ready;
    logic [3:0]  s_wstrb;
    logic [31:0] s_wdata, s_addr, s_rdata;
    logic        timeout_err;

    int total;
    int bad;

    mem_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_wstrb(m0_wstrb),
        .m0_wdata(m0_wdata), .m0_addr(m0_addr), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_wstrb(m1_wstrb),
        .m1_wdata(m1_wdata), .m1_addr(m1_addr), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_wstrb(s_wstrb), .s_wdata(s_wdata),
        .s_addr(s_addr), .s_ready(s_ready), .s_rdata(s_rdata),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL rst_s_valid got=%0h exp=0", s_valid); end
        total++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0h%0h exp=00", m0_ready, m1_ready); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout_err got=%0h exp=0", timeout_err); end
        total++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0/0", m0_rdata, m1_rdata); end
        reset = 1'b0;
        settle();
    endtask

    task automatic test_single_read();
        m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'b0000;
        tick();
        total++; if (s_valid !== 1'b1 || s_addr !== 32'h100) begin bad++; $display("FAIL rd_req got=%0h/%h exp=1/00000100", s_valid, s_addr); end
        total++; if (m0_ready !== 1'b0) begin bad++; $display("FAIL rd_wait_ready got=%0h exp=0", m0_ready); end
        tick();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        settle();
        total++; if (m0_ready !== 1'b1 || m0_rdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_done got=%0h/%h exp=1/12345678", m0_ready, m0_rdata); end
        total++; if (m1_ready !== 1'b0 || m1_rdata !== 32'h0) begin bad++; $display("FAIL rd_other got=%0h/%h exp=0/0", m1_ready, m1_rdata); end
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;
        settle();
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL rd_idle_gap got=%0h exp=0", s_valid); end
    endtask

    task automatic test_alternation();
        apply_reset();
        m0_valid = 1'b1; m0_addr = 32'h200;
        m1_valid = 1'b1; m1_addr = 32'h300;
        tick();
        total++; if (s_addr !== 32'h200) begin bad++; $display("FAIL alt_first got=%h exp=00000200", s_addr); end
        s_ready = 1'b1;
        settle();
        total++; if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin bad++; $display("FAIL alt_first_ready got=%0h%0h exp=10", m0_ready, m1_ready); end
        tick();
        s_ready = 1'b0;
        settle();
        total++; if (s_valid !== 1'b0 || m0_ready !== 1'b0) begin bad++; $display("FAIL alt_gap got=%0h/%0h exp=0/0", s_valid, m0_ready); end
        tick();
        total++; if (s_valid !== 1'b1 || s_addr !== 32'h300) begin bad++; $display("FAIL alt_second got=%0h/%h exp=1/00000300", s_valid, s_addr); end
        s_ready = 1'b1; s_rdata = 32'h0000_0011;
        settle();
        total++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0 || m1_rdata !== 32'h11) begin bad++; $display("FAIL alt_second_ready got=%0h%0h/%h exp=10/00000011", m1_ready, m0_ready, m1_rdata); end
        tick();
        s_ready = 1'b0;
        settle();
        tick();
        total++; if (s_addr !== 32'h200) begin bad++; $display("FAIL alt_third got=%h exp=00000200", s_addr); end
        s_ready = 1'b1;
        tick();
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        settle();
    endtask

    task automatic test_write();
        tick();
        m1_valid = 1'b1; m1_instr = 1'b0; m1_wstrb = 4'b0011;
        m1_wdata = 32'hAAAA_5555; m1_addr = 32'h40;
        tick();
        total++; if (s_wstrb !== 4'b0011 || s_wdata !== 32'hAAAA_5555 || s_addr !== 32'h40) begin bad++; $display("FAIL wr_fields got=%b/%h/%h exp=0011/aaaa5555/00000040", s_wstrb, s_wdata, s_addr); end
        s_ready = 1'b1;
        settle();
        total++; if (m1_ready !== 1'b1) begin bad++; $display("FAIL wr_ready got=%0h exp=1", m1_ready); end
        tick();
        m1_valid = 1'b0; s_ready = 1'b0;
        settle();
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL wr_after got=%0h exp=0", s_valid); end
    endtask

    task automatic test_timeout();
        tick();
        m0_valid = 1'b1; m0_addr = 32'h500; s_rdata = 32'h5555_5555;
        tick();
        total++; if (timeout_err !== 1'b0 || m0_ready !== 1'b0) begin bad++; $display("FAIL to_cycle1 got=%0h/%0h exp=0/0", timeout_err, m0_ready); end
        tick();
        tick();
        total++; if (timeout_err !== 1'b0 || m0_ready !== 1'b0) begin bad++; $display("FAIL to_cycle3 got=%0h/%0h exp=0/0", timeout_err, m0_ready); end
        tick();
        total++; if (m0_ready !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF || timeout_err !== 1'b1) begin bad++; $display("FAIL to_cycle4 got=%0h/%h/%0h exp=1/deadbeef/1", m0_ready, m0_rdata, timeout_err); end
        tick();
        total++; if (timeout_err !== 1'b0 || s_valid !== 1'b0) begin bad++; $display("FAIL to_pulse_end got=%0h/%0h exp=0/0", timeout_err, s_valid); end
        // s_ready in the timeout cycle takes precedence
        tick();
        tick();
        tick();
        tick();
        s_ready = 1'b1; s_rdata = 32'hCAFE_0001;
        settle();
        total++; if (m0_ready !== 1'b1 || m0_rdata !== 32'hCAFE_0001 || timeout_err !== 1'b0) begin bad++; $display("FAIL to_ready_wins got=%0h/%h/%0h exp=1/cafe0001/0", m0_ready, m0_rdata, timeout_err); end
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;
        settle();
    endtask

    task automatic test_reset_mid_grant();
        tick();
        m1_valid = 1'b1; m1_addr = 32'h700;
        tick();
        total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL mr_granted got=%0h exp=1", s_valid); end
        s_ready = 1'b1;
        reset = 1'b1;
        settle();
        total++; if (s_valid !== 1'b0 || m1_ready !== 1'b0) begin bad++; $display("FAIL mr_async got=%0h/%0h exp=0/0", s_valid, m1_ready); end
        tick();
        reset = 1'b0; s_ready = 1'b0;
        m0_valid = 1'b1; m0_addr = 32'h800;
        settle();
        tick();
        total++; if (s_addr !== 32'h800 || s_valid !== 1'b1) begin bad++; $display("FAIL mr_prio got=%h/%0h exp=00000800/1", s_addr, s_valid); end
        s_ready = 1'b1;
        tick();
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        settle();
    endtask

    task automatic test_drop_valid();
        tick();
        m0_valid = 1'b1; m0_addr = 32'h900;
        tick();
        m0_valid = 1'b0; s_ready = 1'b1;
        settle();
        total++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin bad++; $display("FAIL dv_ready got=%0h%0h exp=00", m0_ready, m1_ready); end
        tick();
        s_ready = 1'b0;
        settle();
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL dv_idle got=%0h exp=0", s_valid); end
        m0_valid = 1'b1; m1_valid = 1'b1; m1_addr = 32'hA00;
        tick();
        total++; if (s_addr !== 32'hA00) begin bad++; $display("FAIL dv_prio_kept got=%h exp=00000a00", s_addr); end
        s_ready = 1'b1;
        tick();
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        settle();
    endtask

    task automatic test_idle_ready();
        tick();
        s_ready = 1'b1;
        settle();
        total++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin bad++; $display("FAIL ir_ready got=%0h%0h exp=00", m0_ready, m1_ready); end
        tick();
        total++; if (s_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin bad++; $display("FAIL ir_stay got=%0h/%0h%0h exp=0/00", s_valid, m0_ready, m1_ready); end
        s_ready = 1'b0;
        settle();
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1;
        m0_valid = 1'b0; m0_instr = 1'b0; m0_wstrb = '0; m0_wdata = '0; m0_addr = '0;
        m1_valid = 1'b0; m1_instr = 1'b0; m1_wstrb = '0; m1_wdata = '0; m1_addr = '0;
        s_ready = 1'b0; s_rdata = '0;
        test_reset();
        test_single_read();
        test_alternation();
        test_write();
        test_timeout();
        test_reset_mid_grant();
        test_drop_valid();
        test_idle_ready();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles a grant waits for s_ready before forced completion (1..255).
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on timeout.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 m0_valid, m0_instr  in  1 each  master 0 (CPU) request, instruction-fetch flag.
REQ-006 m0_wstrb  in  4; m0_wdata, m0_addr  in  32 each  master 0 write strobes, data, byte address.
REQ-007 m0_ready  out  1; m0_rdata  out  32  master 0 completion, read data.
REQ-008 m1_valid, m1_instr, m1_wstrb, m1_wdata, m1_addr, m1_ready, m1_rdata: master 1 (loader/debug), widths and directions as master 0.
REQ-009 s_valid, s_instr  out  1; s_wstrb  out  4; s_wdata, s_addr  out  32  request to memory controller.
REQ-010 s_ready  in  1; s_rdata  in  32  memory controller completion, read data.
REQ-011 timeout_err  out  1  one-cycle pulse when a grant completes by timeout.

Function
REQ-012 FSM states: IDLE, GRANT0, GRANT1; state, priority bit and timeout counter are the only state.
REQ-013 IDLE: s_valid=0, both m*_ready=0; exactly one valid master -> its GRANT next cycle; both valid -> master named by priority bit (reset value 0 = m0).
REQ-014 GRANTn: s_valid=1; s_instr/s_wstrb/s_wdata/s_addr driven combinationally from master n; other master's ready held 0.
REQ-015 GRANTn: mn_ready = s_ready combinationally (zero added latency); mn_rdata = s_rdata.
REQ-016 On s_ready=1 in GRANTn: next state IDLE, priority bit set to favour the other master; minimum one IDLE cycle between grants (s_valid deasserts for ≥1 cycle, required by memory controller's per-request ready).
REQ-017 Non-granted master's rdata SHALL be 32'h0.
REQ-018 Counter clears on entering GRANTn, increments each GRANT cycle without s_ready; reaching TIMEOUT with s_ready=0 -> mn_ready=1, mn_rdata=ERR_DATA, timeout_err=1 that cycle, next state IDLE, priority flipped.
REQ-019 s_ready and timeout in same cycle: s_ready wins, s_rdata returned, timeout_err=0.
REQ-020 Granted master drops valid before ready: return to IDLE next cycle, no ready to either master, priority unchanged.
REQ-021 s_ready=1 in IDLE: ignored, no master ready.
REQ-022 New request by completing master in cycle after its ready: served normally; if other master waiting, other master wins (priority flipped).

Reset
REQ-023 Reset asserted (any time, incl. mid-grant): state=IDLE, priority=0, counter=0 immediately; s_valid=0, m0_ready=m1_ready=0, timeout_err=0, rdata outputs 32'h0.
REQ-024 In-flight transaction aborted on reset; no ready issued; first post-reset grant follows REQ-013.

Structure
REQ-025 FSM state encoding (IDLE/GRANT0/GRANT1) and default TIMEOUT/ERR_DATA in shared package mem_bus_pkg, reused by future bus blocks.
REQ-026 One sub-module natural: mem_req_mux (combinational 2:1 mux of request fields by grant select); FSM, counter, priority in mem_arbiter.

Verification
REQ-027 m0 read addr 32'h100, s_ready after 1 cycle, s_rdata 32'h1234_5678 -> m0_ready=1 same cycle, m0_rdata 32'h1234_5678, m1_ready=0.
REQ-028 m0 and m1 valid together from reset -> m0 granted first; m1 granted after one IDLE cycle; next simultaneous request -> m0 again (alternation).
REQ-029 m1 write wstrb 4'b0011 data 32'hAAAA_5555 addr 32'h40 -> s_wstrb 4'b0011, s_wdata/s_addr match, s_valid low in following cycle.
REQ-030 s_ready held 0 with TIMEOUT=4 -> m0_ready=1, m0_rdata 32'hDEAD_BEEF, timeout_err single-cycle pulse on 4th grant cycle.
REQ-031 reset asserted mid-GRANT1 -> s_valid and m1_ready 0 asynchronously; after release, m0-only request granted, priority=0.
REQ-032 s_ready pulsed in IDLE with no valid -> no m*_ready, state stays IDLE.
